// File: rtl/spart_host_driver.sv
// Bus master for the spart UART: programs the baud divisor, then polls rda/tbr to move bytes
// between spart and client valid/ready streams. Define SPART_HOST_ECHO_EN to echo received bytes.
module spart_host_driver #(
    parameter logic [15:0] DIVISOR = 16'd162,
    parameter int          FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       cfg_done,
    output logic       overflow
);

    typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WR, WR_WAIT} state_e;

    localparam int DEPTH = 1 << FIFO_AW;

    state_e           state_q, state_d;
    logic             cfg_go_q, cfg_go_d;
    logic             cfg_done_q, cfg_done_d;
    logic             iocs_q, iocs_d;
    logic             iorw_q, iorw_d;
    logic [1:0]       ioaddr_q, ioaddr_d;
    logic             db_oe_q, db_oe_d;
    logic [7:0]       db_out_q, db_out_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic             fifo_empty, fifo_full;
    logic             push, pop;
    logic [7:0]       push_data, fifo_head;
`ifdef SPART_HOST_ECHO_EN
    logic             overflow_q, overflow_d;
`endif

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign fifo_head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign pop        = (state_q == WR);

`ifdef SPART_HOST_ECHO_EN
    assign tx_ready = cfg_done_q && !fifo_full && (state_q != RD);
    assign overflow = overflow_q;
`else
    assign tx_ready = cfg_done_q && !fifo_full;
    assign overflow = 1'b0;
`endif

    // The echo push shares the write port; the client is locked out during RD so they never meet.
    always_comb begin
        push      = tx_valid && tx_ready;
        push_data = tx_data;
`ifdef SPART_HOST_ECHO_EN
        overflow_d = overflow_q;
        if (state_q == RD) begin
            if (fifo_full) begin
                overflow_d = 1'b1;
            end else begin
                push      = 1'b1;
                push_data = databus;
            end
        end
`endif
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[FIFO_AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
        end
    end

    // cfg_go_q holds CFG_LO for one cycle after reset so its bus write lands in the first free cycle.
    always_comb begin
        state_d    = state_q;
        cfg_go_d   = 1'b1;
        cfg_done_d = cfg_done_q;
        case (state_q)
            CFG_LO: begin
                if (cfg_go_q) begin
                    state_d = CFG_HI;
                end
            end
            CFG_HI: begin
                state_d    = IDLE;
                cfg_done_d = 1'b1;
            end
            IDLE: begin
                if (rda) begin
                    state_d = RD;
                end else if (!fifo_empty && tbr) begin
                    state_d = WR;
                end
            end
            RD:      state_d = IDLE;
            WR:      state_d = WR_WAIT;
            WR_WAIT: state_d = IDLE;
            default: state_d = CFG_LO;
        endcase
    end

    // Bus outputs are decoded from the next state so the registered values line up with state_q.
    always_comb begin
        iocs_d   = 1'b0;
        iorw_d   = 1'b1;
        ioaddr_d = 2'b00;
        db_oe_d  = 1'b0;
        db_out_d = 8'h00;
        case (state_d)
            CFG_LO: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b10;
                db_oe_d  = 1'b1;
                db_out_d = DIVISOR[7:0];
            end
            CFG_HI: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b11;
                db_oe_d  = 1'b1;
                db_out_d = DIVISOR[15:8];
            end
            RD: begin
                iocs_d = 1'b1;
            end
            WR: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                db_oe_d  = 1'b1;
                db_out_d = fifo_head;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        rx_valid_d = (state_q == RD);
        rx_data_d  = (state_q == RD) ? databus : rx_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CFG_LO;
            cfg_go_q   <= 1'b0;
            cfg_done_q <= 1'b0;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= 2'b00;
            db_oe_q    <= 1'b0;
            db_out_q   <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
`ifdef SPART_HOST_ECHO_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cfg_go_q   <= cfg_go_d;
            cfg_done_q <= cfg_done_d;
            iocs_q     <= iocs_d;
            iorw_q     <= iorw_d;
            ioaddr_q   <= ioaddr_d;
            db_oe_q    <= db_oe_d;
            db_out_q   <= db_out_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
`ifdef SPART_HOST_ECHO_EN
            overflow_q <= overflow_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign iocs     = iocs_q;
    assign iorw     = iorw_q;
    assign ioaddr   = ioaddr_q;
    assign databus  = db_oe_q ? db_out_q : 8'hzz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_spart_host_driver.sv
// Directed self-checking bench for spart_host_driver; the bench also plays the spart side of the bus.
// Echo-specific checks are compiled in when SPART_HOST_ECHO_EN is defined.
module tb_spart_host_driver;

    logic       clk = 1'b0;
    logic       rst_n, rda, tbr, tx_valid;
    logic [7:0] tx_data, rd_byte;
    logic       iocs, iorw, tx_ready, rx_valid, cfg_done, overflow;
    logic [1:0] ioaddr;
    logic [7:0] rx_data;
    tri1  [7:0] databus;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic       exp_ovf = 1'b0;
    logic [7:0] wr_log[$];
    int         wr_cyc[$];
    logic [7:0] exp_fifo[$];

    spart_host_driver #(.DIVISOR(16'h00A2), .FIFO_AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .cfg_done(cfg_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // spart answers reads on the shared bus
    assign databus = (iocs && iorw) ? rd_byte : 8'hzz;

    // Log every data-register write on the falling edge, mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (iocs && !iorw && ioaddr == 2'b00) begin
            wr_log.push_back(databus);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic exp_acc, input string tag);
        tx_data  = d;
        tx_valid = 1'b1;
        checkOutput(tag, 32'(tx_ready), 32'(exp_acc));
        if (exp_acc) exp_fifo.push_back(d);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic rxByte(input logic [7:0] b);
        rd_byte = b;
        rda = 1'b1;
        tick();
        checkOutput("rd_bus", 32'({iocs, iorw, ioaddr}), 32'(4'b1100));
        checkOutput("rd_no_valid_yet", 32'(rx_valid), 32'd0);
`ifdef SPART_HOST_ECHO_EN
        checkOutput("rd_tx_ready_blocked", 32'(tx_ready), 32'd0);
        if (exp_fifo.size() < 8) exp_fifo.push_back(b);
        else exp_ovf = 1'b1;
`endif
        rda = 1'b0;
        tick();
        checkOutput("rx_valid", 32'(rx_valid), 32'd1);
        checkOutput("rx_data", 32'(rx_data), 32'(b));
        checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
        tick();
        checkOutput("rx_valid_pulse", 32'(rx_valid), 32'd0);
        checkOutput("rx_data_hold", 32'(rx_data), 32'(b));
    endtask

    task automatic checkLog(input string tag);
        checkOutput({tag, "_count"}, 32'(wr_log.size()), 32'(exp_fifo.size()));
        for (int i = 0; i < exp_fifo.size(); i++) begin
            checkOutput({tag, "_byte"}, 32'((i < wr_log.size()) ? wr_log[i] : 8'hxx), 32'(exp_fifo[i]));
        end
        wr_log.delete();
        wr_cyc.delete();
        exp_fifo.delete();
    endtask

    task automatic waitWr(input int limit);
        int n = 0;
        while (!(iocs && !iorw && ioaddr == 2'b00) && n < limit) begin
            tick();
            n++;
        end
        checkOutput("wr_wait_timeout", 32'(n < limit), 32'd1);
    endtask

    task automatic checkConfig();
        tick();
        checkOutput("cfg_lo_bus", 32'({iocs, iorw, ioaddr}), 32'(4'b1010));
        checkOutput("cfg_lo_data", 32'(databus), 32'h0A2);
        tick();
        checkOutput("cfg_hi_bus", 32'({iocs, iorw, ioaddr}), 32'(4'b1011));
        checkOutput("cfg_hi_data", 32'(databus), 32'h000);
        checkOutput("cfg_done_early", 32'(cfg_done), 32'd0);
        tick();
        checkOutput("cfg_done", 32'(cfg_done), 32'd1);
        checkOutput("idle_bus", 32'({iocs, iorw, ioaddr}), 32'(4'b0100));
        checkOutput("idle_hiz", 32'(databus), 32'h0FF);
        checkOutput("tx_ready_after_cfg", 32'(tx_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; rda = 1'b0; tbr = 1'b0; tx_valid = 1'b0;
        tx_data = 8'h00; rd_byte = 8'h00;
        repeat (3) tick();

        // reset state
        checkOutput("rst_iocs", 32'(iocs), 32'd0);
        checkOutput("rst_iorw", 32'(iorw), 32'd1);
        checkOutput("rst_ioaddr", 32'(ioaddr), 32'd0);
        checkOutput("rst_hiz", 32'(databus), 32'h0FF);
        checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd0);
        checkOutput("rst_cfg_done", 32'(cfg_done), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);

        rst_n = 1'b1;
        checkConfig();

        // single receive
        rxByte(8'h5A);

        // three transmits with tbr held high
        wr_log.delete(); wr_cyc.delete();
        tbr = 1'b1;
        applyStimulus(8'h11, 1'b1, "push_11");
        applyStimulus(8'h22, 1'b1, "push_22");
        applyStimulus(8'h33, 1'b1, "push_33");
        repeat (15) tick();
        checkOutput("wr_spacing", 32'((wr_cyc.size() >= 2) ? wr_cyc[1] - wr_cyc[0] : -1), 32'd3);
        checkOutput("wr_spacing2", 32'((wr_cyc.size() >= 3) ? wr_cyc[2] - wr_cyc[1] : -1), 32'd3);
        tbr = 1'b0;
        checkLog("tx3");

        // fill to full with tbr low, then drain
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'hA0 + 8'(i), (i < 8), "push_fill");
        end
        checkOutput("tx_ready_full", 32'(tx_ready), 32'd0);
        repeat (4) tick();
        checkOutput("no_writes_tbr_low", 32'(wr_log.size()), 32'd0);
        tbr = 1'b1;
        repeat (30) tick();
        tbr = 1'b0;
        checkLog("fill");

        // rda and tbr together: RD first, WR two cycles later
        applyStimulus(8'h77, 1'b1, "push_77");
        rd_byte = 8'h99;
        rda = 1'b1;
        tbr = 1'b1;
        tick();
        checkOutput("prio_rd_bus", 32'({iocs, iorw, ioaddr}), 32'(4'b1100));
`ifdef SPART_HOST_ECHO_EN
        exp_fifo.push_back(8'h99);
`endif
        rda = 1'b0;
        tick();
        checkOutput("prio_rx_valid", 32'(rx_valid), 32'd1);
        checkOutput("prio_rx_data", 32'(rx_data), 32'h099);
        checkOutput("prio_idle", 32'(iocs), 32'd0);
        tick();
        checkOutput("prio_wr_bus", 32'({iocs, iorw, ioaddr}), 32'(4'b1000));
        checkOutput("prio_wr_data", 32'(databus), 32'h077);
        tick();
        checkOutput("wr_wait_iocs", 32'(iocs), 32'd0);
        repeat (10) tick();
        tbr = 1'b0;
        checkLog("prio");

`ifdef SPART_HOST_ECHO_EN
        // echo into a full FIFO drops the byte and sets overflow
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'hC0 + 8'(i), 1'b1, "push_echo_fill");
        end
        checkOutput("echo_full", 32'(tx_ready), 32'd0);
        rxByte(8'hEE);
        checkOutput("echo_overflow", 32'(overflow), 32'd1);
        tbr = 1'b1;
        repeat (30) tick();
        tbr = 1'b0;
        checkLog("echo");
`endif

        // reset in the middle of a write
        applyStimulus(8'h41, 1'b1, "push_41");
        applyStimulus(8'h42, 1'b1, "push_42");
        tbr = 1'b1;
        waitWr(10);
        checkOutput("midwr_data", 32'(databus), 32'h041);
        rst_n = 1'b0;
        tick();
        checkOutput("midrst_iocs", 32'(iocs), 32'd0);
        checkOutput("midrst_hiz", 32'(databus), 32'h0FF);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);
        checkOutput("midrst_cfg_done", 32'(cfg_done), 32'd0);
        checkOutput("midrst_tx_ready", 32'(tx_ready), 32'd0);
        exp_fifo.delete();
        exp_ovf = 1'b0;
        rst_n = 1'b1;
        checkConfig();
        wr_log.delete(); wr_cyc.delete();
        repeat (8) tick();
        checkOutput("fifo_flushed", 32'(wr_log.size()), 32'd0);
        tbr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
